// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF crypto coprocessor.
// The queue entry widths below set the storage width of the pending-instruction queue.
package cvxif_copro_pkg;

  localparam int unsigned COPRO_XLEN     = 32;
  localparam int unsigned COPRO_ID_WIDTH = 4;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] FUNCT3_SBOX    = 3'b000;
  localparam logic [2:0] FUNCT3_XROT    = 3'b001;
  localparam logic [2:0] FUNCT3_CLMUL   = 3'b010;

  typedef enum logic [1:0] {OP_SBOX, OP_XROT, OP_CLMUL} op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESULT} state_e;

  typedef struct packed {
    logic [COPRO_ID_WIDTH-1:0] id;
    op_e                       op;
    logic [4:0]                rd;
    logic [COPRO_XLEN-1:0]     rs1;
    logic [COPRO_XLEN-1:0]     rs2;
    logic                      committed;
    logic                      killed;
  } queue_entry_t;

  function automatic op_e funct3_to_op(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_XROT:  return OP_XROT;
      FUNCT3_CLMUL: return OP_CLMUL;
      default:      return OP_SBOX;
    endcase
  endfunction

endpackage

// File: rtl/copro_aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module copro_aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Row-major table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx;

  assign bit_idx = {~data_i, 3'b000};
  assign data_o  = SBOX_TABLE[bit_idx +: 8];

endmodule

// File: rtl/cvxif_crypto_copro.sv
// CV-X-IF responder: decodes custom-0 crypto ops, queues them until commit,
// executes them one at a time in order and returns results on the result channel.
module cvxif_crypto_copro
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN        = COPRO_XLEN,
  parameter int unsigned ID_WIDTH    = COPRO_ID_WIDTH,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(XLEN);

  queue_entry_t            q [QUEUE_DEPTH];
  queue_entry_t            new_entry;
  queue_entry_t            head;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;
  logic [QUEUE_DEPTH-1:0]  occupied;
  logic                    full, push, pop, load, step;
  logic                    head_hit, head_committed, head_killed;
  logic [2:0]              funct3;
  logic                    op_legal;
  state_e                  state_q, state_d;
  op_e                     cur_op;
  logic [ID_WIDTH-1:0]     cur_id;
  logic [4:0]              cur_rd;
  logic [XLEN-1:0]         opa, opb, acc;
  logic [CNT_W-1:0]        cnt, cnt_last;
  logic [7:0]              sbox_out;
  logic                    unused_instr_bits;

  assign unused_instr_bits = ^issue_instr_i[24:15];

  // Decode
  assign funct3   = issue_instr_i[14:12];
  assign op_legal = (funct3 == FUNCT3_SBOX) || (funct3 == FUNCT3_XROT) || (funct3 == FUNCT3_CLMUL);
  assign issue_accept_o = (issue_instr_i[6:0] == OPCODE_CUSTOM0) && (issue_instr_i[31:25] == 7'd0)
                          && op_legal && (issue_rs_valid_i == 2'b11);
  assign issue_writeback_o = issue_accept_o;

  assign full          = (count == (PTR_W+1)'(QUEUE_DEPTH));
  assign issue_ready_o = !full;
  assign push          = issue_valid_i && issue_ready_o && issue_accept_o;

  // A commit arriving with its own issue lands directly in the new entry.
  always_comb begin
    new_entry           = '0;
    new_entry.id        = COPRO_ID_WIDTH'(issue_id_i);
    new_entry.op        = funct3_to_op(funct3);
    new_entry.rd        = issue_instr_i[11:7];
    new_entry.rs1       = COPRO_XLEN'(issue_rs1_i);
    new_entry.rs2       = COPRO_XLEN'(issue_rs2_i);
    new_entry.committed = commit_valid_i && (commit_id_i == issue_id_i) && !commit_kill_i;
    new_entry.killed    = commit_valid_i && (commit_id_i == issue_id_i) && commit_kill_i;
  end

  always_comb begin
    occupied = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      occupied[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (commit_valid_i && occupied[i] && (q[i].id == COPRO_ID_WIDTH'(commit_id_i))) begin
          q[i].committed <= !commit_kill_i;
          q[i].killed    <= commit_kill_i;
        end
      end
      if (push) begin
        q[wr_ptr] <= new_entry;
        wr_ptr    <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Same-cycle commit of the head is seen by IDLE without waiting for the flag.
  assign head           = q[rd_ptr];
  assign head_hit       = commit_valid_i && (count != '0) && (COPRO_ID_WIDTH'(commit_id_i) == head.id);
  assign head_committed = head.committed || (head_hit && !commit_kill_i);
  assign head_killed    = head.killed || (head_hit && commit_kill_i);

  always_comb begin
    case (cur_op)
      OP_XROT:  cnt_last = '0;
      OP_CLMUL: cnt_last = CNT_W'(XLEN - 1);
      default:  cnt_last = CNT_W'(XLEN / 8 - 1);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          if (head_killed) begin
            pop = 1'b1;
          end else if (head_committed) begin
            load    = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        step = 1'b1;
        if (cnt == cnt_last) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  copro_aes_sbox u_sbox (
    .data_i (opa[7:0]),
    .data_o (sbox_out)
  );

  // Execution datapath: SBOX shifts result bytes in from the top, CLMUL walks rs2 LSB first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      cur_op <= OP_SBOX;
      cur_id <= '0;
      cur_rd <= '0;
    end else if (load) begin
      opa    <= XLEN'(head.rs1);
      opb    <= XLEN'(head.rs2);
      acc    <= '0;
      cnt    <= '0;
      cur_op <= head.op;
      cur_id <= ID_WIDTH'(head.id);
      cur_rd <= head.rd;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      case (cur_op)
        OP_XROT: acc <= opa ^ {opb[XLEN-9:0], opb[XLEN-1:XLEN-8]};
        OP_CLMUL: begin
          if (opb[0]) acc <= acc ^ opa;
          opa <= opa << 1;
          opb <= opb >> 1;
        end
        default: begin
          acc <= {sbox_out, acc[XLEN-1:8]};
          opa <= opa >> 8;
        end
      endcase
    end
  end

  assign result_valid_o = (state_q == ST_RESULT);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = cur_id;
  assign result_rd_o    = cur_rd;
  assign result_data_o  = acc;

endmodule
